// File: rtl/pipelined_alu_mc.sv
// Handshaked ALU with registered flags, a persistent carry for rotates, and
// iterative unsigned multiply (shift-add) / divide (restoring) over WIDTH cycles.
module pipelined_alu_mc #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 6,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH-1:0] rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rz,
  output logic [WIDTH-1:0] rz_hi,
  output logic [4:0]       flags,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int MSB = WIDTH - 1;
  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_NEG   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_COMP  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_LSR   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_ASR   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_LSL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ROR   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ROL   = OP_W'(12);
  localparam logic [OP_W-1:0] OP_MOVE  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_PASSB = OP_W'(15);
  localparam logic [OP_W-1:0] OP_MUL   = OP_W'(19);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(20);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [WIDTH-1:0] opd, acc_hi, acc_lo;

  // Handshake: a transfer happens on an edge where valid & ready are both high.
  // in_valid/operands must be held by upstream until in_ready; out_valid with
  // rz/rz_hi/flags stays stable until out_ready.
  logic accept, is_mc, last_iter;
  assign in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign is_mc     = (op == OP_MUL) || (op == OP_DIVU);
  assign last_iter = (state == S_BUSY) && (cnt == CNT_W'(1));
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_BUSY);
  assign state_dbg = state;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (op == OP_NOP)  state_n = S_IDLE;
          else if (is_mc)    state_n = S_BUSY;
          else               state_n = S_DONE;
        end else if ((state == S_DONE) && out_ready) begin
          state_n = S_IDLE;
        end
      end
      S_BUSY:  if (last_iter) state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // Single-cycle result; ROR/ROL pull in the carry currently held in flags.
  logic [WIDTH-1:0] sc_rz;
  logic             sc_c, sc_v, sc_inr;
  always_comb begin
    sc_rz  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_inr = 1'b0;
    case (op)
      OP_NOP, OP_MUL, OP_DIVU: sc_inr = 1'b0;
      OP_ADD: begin
        {sc_c, sc_rz} = {1'b0, ra} + {1'b0, rb};
        sc_v = (ra[MSB] == rb[MSB]) && (sc_rz[MSB] != ra[MSB]);
      end
      OP_SUB: begin
        sc_rz = ra - rb;
        sc_c  = (ra < rb);
        sc_v  = (ra[MSB] != rb[MSB]) && (sc_rz[MSB] != ra[MSB]);
      end
      OP_NEG: begin
        sc_rz = '0 - ra;
        sc_c  = |ra;
        sc_v  = ra[MSB] & sc_rz[MSB];
      end
      OP_AND:   sc_rz = ra & rb;
      OP_OR:    sc_rz = ra | rb;
      OP_XOR:   sc_rz = ra ^ rb;
      OP_COMP:  sc_rz = ~ra;
      OP_LSR:   sc_rz = {1'b0, ra[MSB:1]};
      OP_ASR:   begin sc_rz = {ra[MSB], ra[MSB:1]};       sc_c = ra[0];   end
      OP_LSL:   begin sc_rz = {ra[MSB-1:0], 1'b0};        sc_c = ra[MSB]; end
      OP_ROR:   begin sc_rz = {flags[0], ra[MSB:1]};      sc_c = ra[0];   end
      OP_ROL:   begin sc_rz = {ra[MSB-1:0], flags[0]};    sc_c = ra[MSB]; end
      OP_MOVE:  sc_rz = ra;
      OP_PASSB: sc_rz = rb;
      default:  sc_inr = 1'b1;
    endcase
  end

  // One MUL or DIVU step. MUL: acc_lo starts as the multiplier, opd the
  // multiplicand. DIVU: acc_lo starts as the dividend and collects quotient bits.
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff, it_hi, it_lo;
  logic             div_ge, mc_c, mc_v;
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
    div_shift = {acc_hi, acc_lo[MSB]};
    div_ge    = (div_shift >= {1'b0, opd});
    div_diff  = div_shift[MSB:0] - opd;
    if (is_div) begin
      it_hi = div_ge ? div_diff : div_shift[MSB:0];
      it_lo = {acc_lo[MSB-1:0], div_ge};
    end else begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], acc_lo[MSB:1]};
    end
    mc_c = is_div ? 1'b0 : (it_hi != '0);
    mc_v = is_div ? (opd == '0) : (it_hi != '0);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      rz     <= '0;
      rz_hi  <= '0;
      flags  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      opd    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
    end else if (accept && op != OP_NOP) begin
      if (is_mc) begin
        cnt    <= CNT_W'(WIDTH);
        is_div <= (op == OP_DIVU);
        opd    <= (op == OP_DIVU) ? rb : ra;
        acc_hi <= '0;
        acc_lo <= (op == OP_DIVU) ? ra : rb;
      end else begin
        rz    <= sc_rz;
        rz_hi <= '0;
        flags <= {sc_inr, sc_rz[MSB] & ~sc_inr, (sc_rz == '0) & ~sc_inr, sc_v, sc_c};
      end
    end else if (state == S_BUSY) begin
      cnt    <= cnt - CNT_W'(1);
      acc_hi <= it_hi;
      acc_lo <= it_lo;
      if (last_iter) begin
        rz    <= it_lo;
        rz_hi <= it_hi;
        flags <= {1'b0, it_lo[MSB], (it_lo == '0), mc_v, mc_c};
      end
    end
  end

endmodule

// File: tb/tb_pipelined_alu_mc.sv
// Bench for pipelined_alu_mc: directed scenarios plus randomized ops checked
// against an arithmetic reference model with carry tracking and backpressure.
module tb_pipelined_alu_mc;
  localparam int W = 32;
  localparam logic [5:0] NOP = 6'd0, ADD = 6'd1, SUB = 6'd2, AND = 6'd3, OR = 6'd4,
    NEG = 6'd5, XOR = 6'd6, COMP = 6'd7, LSR = 6'd8, ASR = 6'd9, LSL = 6'd10,
    ROR = 6'd11, ROL = 6'd12, MOVE = 6'd13, PASSB = 6'd15, MUL = 6'd19, DIVU = 6'd20;

  logic Clock = 1'b0, Resetn, in_valid, in_ready, out_valid, out_ready, busy;
  logic [5:0] op;
  logic [W-1:0] ra, rb, rz, rz_hi;
  logic [4:0] flags;
  logic [1:0] state_dbg;
  int n_cmp = 0, n_mis = 0;
  bit model_c = 1'b0;

  pipelined_alu_mc #(.WIDTH(W), .OP_W(6)) dut (
    .Clock(Clock), .Resetn(Resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .ra(ra), .rb(rb), .out_valid(out_valid), .out_ready(out_ready),
    .rz(rz), .rz_hi(rz_hi), .flags(flags), .busy(busy), .state_dbg(state_dbg));

  // clock / reset / watchdog
  always #5 Clock = ~Clock;
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Reference model: plain arithmetic on wide integers; flags = {INR,N,Z,V,C}.
  function automatic void ref_model(input logic [5:0] o, input logic [W-1:0] a, b,
                                    input bit cin, output logic [W-1:0] ez, ezh,
                                    output logic [4:0] ef);
    longint sa, sb, s;
    longint lim = 64'sd2147483647;
    logic [63:0] p;
    bit c, v, inr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; inr = 1'b0; ez = '0; ezh = '0;
    case (o)
      ADD:   begin p = 64'(a) + 64'(b); ez = p[31:0]; c = p[32]; s = sa + sb; v = (s > lim) || (s < -lim - 1); end
      SUB:   begin ez = a - b; c = (a < b); s = sa - sb; v = (s > lim) || (s < -lim - 1); end
      NEG:   begin ez = -a; c = (a != 0); s = -sa; v = (s > lim) || (s < -lim - 1); end
      AND:   ez = a & b;
      OR:    ez = a | b;
      XOR:   ez = a ^ b;
      COMP:  ez = ~a;
      LSR:   ez = a >> 1;
      ASR:   begin ez = $signed(a) >>> 1; c = a[0]; end
      LSL:   begin ez = a << 1; c = a[W-1]; end
      ROR:   begin ez = (a >> 1) | (W'(cin) << (W - 1)); c = a[0]; end
      ROL:   begin ez = (a << 1) | W'(cin); c = a[W-1]; end
      MOVE:  ez = a;
      PASSB: ez = b;
      MUL:   begin p = 64'(a) * 64'(b); ez = p[31:0]; ezh = p[63:32]; c = (ezh != 0); v = c; end
      DIVU:  if (b == 0) begin ez = '1; ezh = a; v = 1'b1; end
             else begin ez = a / b; ezh = a % b; end
      default: inr = 1'b1;
    endcase
    ef = {inr, inr ? 1'b0 : ez[W-1], inr ? 1'b0 : (ez == 0), v, c};
  endfunction

  // Driver: present one op, wait for the transfer, then count edges to out_valid.
  task automatic run_op(input logic [5:0] o, input logic [W-1:0] a, b,
                        output bit ok, output int edges, output int busy_n, output int ready_n);
    int n = 0;
    ok = 1'b0; edges = 0; busy_n = 0; ready_n = 0;
    @(negedge Clock);
    op = o; ra = a; rb = b; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge Clock); n++; end
    if (!in_ready) begin in_valid = 1'b0; return; end
    @(posedge Clock); #1;
    in_valid = 1'b0; op = 6'($urandom); ra = $urandom; rb = $urandom;
    if (o == NOP) begin ok = 1'b1; return; end
    while (!out_valid && edges < 100) begin
      busy_n += int'(busy); ready_n += int'(in_ready);
      @(posedge Clock); #1; edges++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; ra = '0; rb = '0;
    repeat (3) @(negedge Clock);
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL reset_held: out_valid=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready);
    end
    Resetn = 1'b1;
    repeat (2) begin @(posedge Clock); #1; end
    n_cmp++;
    if (out_valid !== 1'b0 || flags !== 5'b0 || in_ready !== 1'b1 || busy !== 1'b0 || rz !== '0 || rz_hi !== '0) begin
      n_mis++; $display("FAIL reset_release: out_valid=%b flags=%b in_ready=%b busy=%b rz=%h rz_hi=%h expected 0 00000 1 0 0 0",
                        out_valid, flags, in_ready, busy, rz, rz_hi);
    end
    model_c = 1'b0;
  endtask

  task automatic test_single_cycle();
    logic [5:0]   t_op[12] = '{ADD, ADD, SUB, ROR, NEG, ASR, LSL, ROL, XOR, COMP, MOVE, PASSB};
    logic [W-1:0] t_a[12]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'd3, 32'h2, 32'h80000000, 32'h80000003,
                               32'hC0000000, 32'h40000001, 32'hF0F0F0F0, 32'h0, 32'h12345678, 32'h0};
    logic [W-1:0] t_b[12]  = '{32'h1, 32'h1, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                               32'hFF00FF00, 32'h0, 32'h0, 32'hCAFEF00D};
    logic [W-1:0] ez, ezh;
    logic [4:0] ef;
    bit ok;
    int e, bn, rn;
    for (int i = 0; i < 12; i++) begin
      ref_model(t_op[i], t_a[i], t_b[i], model_c, ez, ezh, ef);
      run_op(t_op[i], t_a[i], t_b[i], ok, e, bn, rn);
      n_cmp++;
      if (!ok || e !== 0) begin
        n_mis++; $display("FAIL single_latency[%0d]: ok=%b extra_edges=%0d expected 1 0", i, ok, e);
      end
      n_cmp++;
      if (rz !== ez || rz_hi !== ezh || flags !== ef) begin
        n_mis++; $display("FAIL single_result[%0d] op=%0d: rz=%h rz_hi=%h flags=%b expected %h %h %b",
                          i, t_op[i], rz, rz_hi, flags, ez, ezh, ef);
      end
      model_c = ef[0];
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] ez, ezh;
    logic [4:0] ef;
    bit ok;
    int e, bn, rn;
    ref_model(MUL, 32'h10000, 32'h10000, model_c, ez, ezh, ef);
    run_op(MUL, 32'h10000, 32'h10000, ok, e, bn, rn);
    n_cmp++;
    if (!ok || e + 1 !== W + 1) begin
      n_mis++; $display("FAIL mul_latency: ok=%b edges_from_accept=%0d expected %0d", ok, e + 1, W + 1);
    end
    n_cmp++;
    if (bn !== W || rn !== 0) begin
      n_mis++; $display("FAIL mul_busy: busy_cycles=%0d ready_cycles=%0d expected %0d 0", bn, rn, W);
    end
    n_cmp++;
    if (rz !== ez || rz_hi !== ezh || flags !== ef) begin
      n_mis++; $display("FAIL mul_result: rz=%h rz_hi=%h flags=%b expected %h %h %b", rz, rz_hi, flags, ez, ezh, ef);
    end
    model_c = ef[0];
  endtask

  task automatic test_divu_stall();
    logic [W-1:0] ez, ezh;
    logic [4:0] ef;
    bit ok;
    int e, bn, rn;
    ref_model(DIVU, 32'd100, 32'd7, model_c, ez, ezh, ef);
    run_op(DIVU, 32'd100, 32'd7, ok, e, bn, rn);
    n_cmp++;
    if (!ok || e !== W || rz !== ez || rz_hi !== ezh || flags !== ef) begin
      n_mis++; $display("FAIL divu_100_7: ok=%b edges=%0d rz=%h rz_hi=%h flags=%b expected 1 %0d %h %h %b",
                        ok, e, rz, rz_hi, flags, W, ez, ezh, ef);
    end
    model_c = ef[0];
    ref_model(DIVU, 32'd5, 32'd0, model_c, ez, ezh, ef);
    run_op(DIVU, 32'd5, 32'd0, ok, e, bn, rn);
    out_ready = 1'b0;
    n_cmp++;
    if (!ok || e !== W || rz !== ez || rz_hi !== ezh || flags !== ef) begin
      n_mis++; $display("FAIL divu_by_zero: ok=%b edges=%0d rz=%h rz_hi=%h flags=%b expected 1 %0d %h %h %b",
                        ok, e, rz, rz_hi, flags, W, ez, ezh, ef);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || rz !== ez || rz_hi !== ezh || flags !== ef) begin
        n_mis++; $display("FAIL divu_stall[%0d]: out_valid=%b in_ready=%b rz=%h rz_hi=%h flags=%b expected 1 0 %h %h %b",
                          i, out_valid, in_ready, rz, rz_hi, flags, ez, ezh, ef);
      end
    end
    out_ready = 1'b1;
    model_c = ef[0];
  endtask

  task automatic test_unrec_nop();
    logic [W-1:0] ez, ezh;
    logic [4:0] ef;
    bit ok, seen;
    int e, bn, rn;
    ref_model(6'd63, 32'hDEADBEEF, 32'h1, model_c, ez, ezh, ef);
    run_op(6'd63, 32'hDEADBEEF, 32'h1, ok, e, bn, rn);
    n_cmp++;
    if (!ok || e !== 0 || rz !== ez || rz_hi !== ezh || flags !== ef) begin
      n_mis++; $display("FAIL unrecognised_op: ok=%b edges=%0d rz=%h rz_hi=%h flags=%b expected 1 0 %h %h %b",
                        ok, e, rz, rz_hi, flags, ez, ezh, ef);
    end
    model_c = ef[0];
    run_op(NOP, 32'h1, 32'h2, ok, e, bn, rn);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin seen |= out_valid; @(posedge Clock); #1; end
    n_cmp++;
    if (!ok || seen !== 1'b0 || flags !== ef || in_ready !== 1'b1) begin
      n_mis++; $display("FAIL nop: ok=%b out_valid_seen=%b flags=%b in_ready=%b expected 1 0 %b 1", ok, seen, flags, in_ready, ef);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ez, ezh;
    logic [4:0] ef;
    bit ok;
    int e, bn, rn;
    ref_model(LSL, 32'h80000000, 32'h0, model_c, ez, ezh, ef);
    run_op(LSL, 32'h80000000, 32'h0, ok, e, bn, rn);
    model_c = ef[0];
    n_cmp++;
    if (!ok || out_valid !== 1'b1 || in_ready !== 1'b1 || flags !== ef) begin
      n_mis++; $display("FAIL b2b_ready: ok=%b out_valid=%b in_ready=%b flags=%b expected 1 1 1 %b", ok, out_valid, in_ready, flags, ef);
    end
    ref_model(ROL, 32'h0, 32'h0, model_c, ez, ezh, ef);
    run_op(ROL, 32'h0, 32'h0, ok, e, bn, rn);
    n_cmp++;
    if (!ok || e !== 0 || rz !== ez || flags !== ef) begin
      n_mis++; $display("FAIL b2b_rol_carry: ok=%b edges=%0d rz=%h flags=%b expected 1 0 %h %b", ok, e, rz, flags, ez, ef);
    end
    model_c = ef[0];
  endtask

  task automatic test_reset_mid_mul();
    bit seen = 1'b0;
    @(negedge Clock);
    op = MUL; ra = $urandom; rb = $urandom; in_valid = 1'b1;
    @(posedge Clock); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || rz !== '0 || rz_hi !== '0 || flags !== 5'b0) begin
      n_mis++; $display("FAIL reset_mid_mul: out_valid=%b busy=%b in_ready=%b rz=%h rz_hi=%h flags=%b expected 0 0 1 0 0 00000",
                        out_valid, busy, in_ready, rz, rz_hi, flags);
    end
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    model_c = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge Clock); #1; seen |= out_valid; end
    n_cmp++;
    if (seen !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_mis++; $display("FAIL reset_abort: out_valid_seen=%b in_ready=%b busy=%b expected 0 1 0", seen, in_ready, busy);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops[16] = '{ADD, SUB, AND, OR, NEG, XOR, COMP, LSR, ASR, LSL, ROR, ROL, MOVE, PASSB, MUL, DIVU};
    logic [W-1:0] a, b, ez, ezh;
    logic [4:0] ef;
    logic [5:0] o;
    bit ok;
    int e, bn, rn, r, k, exp_e;
    for (int i = 0; i < 70; i++) begin
      r = $urandom_range(0, 16);
      o = (r < 16) ? ops[r] : 6'($urandom_range(21, 63));
      a = $urandom;
      b = $urandom;
      if (o == DIVU && $urandom_range(0, 3) == 0) b = '0;
      else if (o == DIVU && $urandom_range(0, 1) == 0) b = $urandom_range(1, 1000);
      exp_e = (o == MUL || o == DIVU) ? W : 0;
      ref_model(o, a, b, model_c, ez, ezh, ef);
      run_op(o, a, b, ok, e, bn, rn);
      n_cmp++;
      if (!ok || e !== exp_e || rn !== 0 || rz !== ez || rz_hi !== ezh || flags !== ef) begin
        n_mis++; $display("FAIL random[%0d] op=%0d a=%h b=%h: ok=%b edges=%0d ready_busy=%0d rz=%h rz_hi=%h flags=%b expected %0d 0 %h %h %b",
                          i, o, a, b, ok, e, rn, rz, rz_hi, flags, exp_e, ez, ezh, ef);
      end
      model_c = ef[0];
      k = $urandom_range(0, 2);
      if (k > 0) begin
        out_ready = 1'b0;
        repeat (k) begin @(posedge Clock); #1; end
        n_cmp++;
        if (out_valid !== 1'b1 || rz !== ez || rz_hi !== ezh || flags !== ef) begin
          n_mis++; $display("FAIL random_hold[%0d]: out_valid=%b rz=%h rz_hi=%h flags=%b expected 1 %h %h %b",
                            i, out_valid, rz, rz_hi, flags, ez, ezh, ef);
        end
        out_ready = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_divu_stall();
    test_unrec_nop();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
